// File: rtl/regfile_burst_ctrl.sv
// Burst read/write initiator for a 16x8 register file with a one-cycle registered read.
// It drives the file's address, en_write and data_in pins and returns read words over a valid/ready stream.
module regfile_burst_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_address,
    output logic              rf_en_write,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out
);

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE,
        S_WR_WAIT,
        S_WR_PULSE,
        S_RD_ISSUE,
        S_RD_CAPTURE,
        S_RD_HOLD,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [ADDR_W-1:0] cur_addr_d;
    logic [ADDR_W-1:0] remaining_q;
    logic [ADDR_W-1:0] remaining_d;

    logic              cmd_ready_d;
    logic              wr_ready_d;
    logic              rd_valid_d;
    logic              busy_d;
    logic              done_d;
    logic              rf_en_write_d;
    logic [ADDR_W-1:0] rf_address_d;
    logic [DATA_W-1:0] rf_data_in_d;
    logic [DATA_W-1:0] rd_data_d;

    // State, burst counters and every output are registered here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            cmd_ready   <= 1'b0;
            wr_ready    <= 1'b0;
            rd_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rf_en_write <= 1'b0;
            rf_address  <= '0;
            rf_data_in  <= '0;
            rd_data     <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            cmd_ready   <= cmd_ready_d;
            wr_ready    <= wr_ready_d;
            rd_valid    <= rd_valid_d;
            busy        <= busy_d;
            done        <= done_d;
            rf_en_write <= rf_en_write_d;
            rf_address  <= rf_address_d;
            rf_data_in  <= rf_data_in_d;
            rd_data     <= rd_data_d;
        end
    end

    // Next state and burst bookkeeping; the address wraps naturally at ADDR_W bits.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    state_d     = cmd_write ? S_WR_WAIT : S_RD_ISSUE;
                end
            end
            S_WR_WAIT: begin
                if (wr_valid && wr_ready) state_d = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                    state_d     = S_WR_WAIT;
                end
            end
            S_RD_ISSUE:   state_d = S_RD_CAPTURE;
            S_RD_CAPTURE: state_d = S_RD_HOLD;
            S_RD_HOLD: begin
                if (rd_valid && rd_ready) begin
                    if (remaining_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cur_addr_d  = cur_addr_q + ADDR_W'(1);
                        remaining_d = remaining_q - ADDR_W'(1);
                        state_d     = S_RD_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the state being entered.
    always_comb begin
        cmd_ready_d   = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        wr_ready_d    = (state_d == S_WR_WAIT);
        rf_en_write_d = (state_d == S_WR_PULSE);
        rd_valid_d    = (state_d == S_RD_HOLD);
        done_d        = (state_d == S_DONE);
        rf_address_d  = rf_address;
        rf_data_in_d  = rf_data_in;
        rd_data_d     = rd_data;
        if (state_q == S_WR_WAIT && state_d == S_WR_PULSE) begin
            rf_address_d = cur_addr_q;
            rf_data_in_d = wr_data;
        end
        if (state_d == S_RD_ISSUE) rf_address_d = cur_addr_d;
        // The file's write-cycle zeroing never lands here: en_write is low in all read states.
        if (state_q == S_RD_CAPTURE) rd_data_d = rf_data_out;
    end

endmodule

// File: tb/tb_regfile_burst_ctrl.sv
// Self-checking bench for regfile_burst_ctrl with a behavioural 16x8 register file attached.
// It runs table-driven bursts, hand-written corner sequences and random bursts against an array model.
`timescale 1ns/1ps
module tb_regfile_burst_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rf_address;
    logic              rf_en_write;
    logic [DATA_W-1:0] rf_data_in;
    logic [DATA_W-1:0] rf_data_out;

    always #5 clock = ~clock;

    regfile_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done),
        .rf_address(rf_address), .rf_en_write(rf_en_write),
        .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
    );

    // Register file: synchronous write, registered read, output zeroed on write cycles.
    logic [DATA_W-1:0] rf_mem [DEPTH];
    always @(posedge clock) begin
        if (rf_en_write) rf_mem[rf_address] <= rf_data_in;
        rf_data_out <= rf_en_write ? '0 : rf_mem[rf_address];
    end

    int cyc;
    int done_cnt;
    logic [ADDR_W-1:0] we_addr_q [$];
    logic [DATA_W-1:0] we_data_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n) begin
            if (done) done_cnt <= done_cnt + 1;
            if (rf_en_write) begin
                we_addr_q.push_back(rf_address);
                we_data_q.push_back(rf_data_in);
            end
        end
    end

    logic [DATA_W-1:0] mem_ref [DEPTH];
    int checks;
    int errors;
    int obs_words;
    int obs_first;
    int obs_last;

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] len;
        logic [DATA_W-1:0] base;
        int                stall_word;
        int                stall_n;
        int                exp_words;
        int                exp_first;
        int                exp_last;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_cmd(input logic w, input logic [ADDR_W-1:0] a,
                             input logic [ADDR_W-1:0] l, output int acc);
        int n;
        n = 0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_accept", int'(cmd_ready), 1);
        acc = cyc;
        tick();
        cmd_valid = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 100) begin
            tick();
            n++;
        end
        chk("done_seen", int'(done_cnt != d0), 1);
        chk("idle_cmd_ready", int'(cmd_ready), 1);
        chk("idle_busy", int'(busy), 0);
        tick();
        tick();
        chk("done_pulses", done_cnt - d0, 1);
    endtask

    task automatic run_write(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l,
                             input logic [DATA_W-1:0] base, input bit rnd,
                             input int stall_word, input int stall_n);
        int acc, d0, q0, n, s;
        logic [DATA_W-1:0] d [DEPTH];
        d0 = done_cnt;
        q0 = we_addr_q.size();
        for (int i = 0; i < int'(DEPTH); i++)
            d[i] = rnd ? DATA_W'($urandom) : DATA_W'(int'(base) + i);
        start_cmd(1'b1, a, l, acc);
        for (int i = 0; i <= int'(l); i++) begin
            s = rnd ? int'($urandom_range(0, 3)) : ((i == stall_word) ? stall_n : 0);
            wr_valid = 1'b0;
            for (int k = 0; k < s; k++) begin
                tick();
                chk("stall_no_we", int'(rf_en_write), 0);
                chk("stall_wr_ready", int'(wr_ready), 1);
            end
            wr_data  = d[i];
            wr_valid = 1'b1;
            n = 0;
            while (!wr_ready && n < 20) begin
                tick();
                n++;
            end
            chk("wr_ready", int'(wr_ready), 1);
            tick();
            wr_valid = 1'b0;
            chk("we_pulse", int'(rf_en_write), 1);
        end
        wait_done(d0);
        obs_words = we_addr_q.size() - q0;
        chk("we_count", obs_words, int'(l) + 1);
        for (int i = 0; i <= int'(l) && q0 + i < we_addr_q.size(); i++) begin
            chk("we_addr", int'(we_addr_q[q0 + i]), (int'(a) + i) % int'(DEPTH));
            chk("we_data", int'(we_data_q[q0 + i]), int'(d[i]));
        end
        obs_first = (obs_words > 0) ? int'(we_addr_q[q0]) : -1;
        obs_last  = (obs_words > 0) ? int'(we_addr_q[we_addr_q.size() - 1]) : -1;
        for (int i = 0; i <= int'(l); i++) mem_ref[ADDR_W'(int'(a) + i)] = d[i];
    endtask

    task automatic run_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l,
                            input bit rnd, input int stall_word, input int stall_n,
                            input bit poke);
        int acc, d0, q0, n, got, stall_left, stalled, prev_v;
        int wc [DEPTH];
        logic [DATA_W-1:0] held_data;
        logic [ADDR_W-1:0] held_addr;
        for (int i = 0; i < int'(DEPTH); i++) wc[i] = 0;
        held_data = '0;
        held_addr = '0;
        d0 = done_cnt;
        q0 = we_addr_q.size();
        obs_first = -1;
        obs_last  = -1;
        start_cmd(1'b0, a, l, acc);
        got = 0;
        n = 0;
        stall_left = stall_n;
        stalled = 0;
        prev_v = 0;
        rd_ready = 1'b1;
        while (got <= int'(l) && n < 400) begin
            if (poke) begin
                cmd_valid = (n < 4);
                cmd_write = 1'b1;
                cmd_addr  = '0;
                cmd_len   = '0;
                if (n < 4) chk("busy_cmd_ready", int'(cmd_ready), 0);
            end
            if (rd_valid) begin
                if (prev_v == 0) wc[got] = cyc;
                if (got == stall_word && stall_left > 0) begin
                    if (stall_left == stall_n) begin
                        held_data = rd_data;
                        held_addr = rf_address;
                    end else begin
                        chk("bp_data_stable", int'(rd_data), int'(held_data));
                        chk("bp_addr_hold", int'(rf_address), int'(held_addr));
                    end
                    rd_ready = 1'b0;
                    stall_left--;
                    stalled++;
                end else begin
                    rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (rd_ready) begin
                        chk("rd_data", int'(rd_data), int'(mem_ref[ADDR_W'(int'(a) + got)]));
                        if (got == 0) obs_first = int'(rd_data);
                        obs_last = int'(rd_data);
                        got++;
                    end
                end
            end else begin
                rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            prev_v = int'(rd_valid);
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        rd_ready  = 1'b1;
        obs_words = got;
        chk("rd_words", got, int'(l) + 1);
        chk("rd_first_latency", wc[0] - acc, 3);
        if (!rnd && stall_n == 0)
            for (int i = 1; i < got; i++) chk("rd_spacing", wc[i] - wc[i-1], 3);
        if (stall_n > 0) chk("bp_cycles", stalled, stall_n);
        wait_done(d0);
        chk("rd_no_we", we_addr_q.size() - q0, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc, n;
        checks = 0;
        errors = 0;
        for (int i = 0; i < int'(DEPTH); i++) mem_ref[i] = '0;

        vecs[0] = '{1'b1, 4'd3,  4'd0,  8'hA5, -1, 0, 1,  3,     3};
        vecs[1] = '{1'b0, 4'd3,  4'd0,  8'h00, -1, 0, 1,  'hA5,  'hA5};
        vecs[2] = '{1'b1, 4'd0,  4'd15, 8'h10, -1, 0, 16, 0,     15};
        vecs[3] = '{1'b0, 4'd0,  4'd15, 8'h00, -1, 0, 16, 'h10,  'h1F};
        vecs[4] = '{1'b1, 4'd14, 4'd3,  8'h01,  1, 4, 4,  14,    1};
        vecs[5] = '{1'b0, 4'd14, 4'd3,  8'h00,  2, 5, 4,  1,     4};

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_data   = '0;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        tick();
        tick();
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_ready", int'(wr_ready), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_en_write", int'(rf_en_write), 0);
        chk("rst_rf_address", int'(rf_address), 0);
        chk("rst_rf_data_in", int'(rf_data_in), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_cmd_ready", int'(cmd_ready), 1);

        for (int v = 0; v < NVEC; v++) begin
            if (vecs[v].wr)
                run_write(vecs[v].addr, vecs[v].len, vecs[v].base, 1'b0,
                          vecs[v].stall_word, vecs[v].stall_n);
            else
                run_read(vecs[v].addr, vecs[v].len, 1'b0,
                         vecs[v].stall_word, vecs[v].stall_n, 1'b0);
            chk($sformatf("vec%0d_words", v), obs_words, vecs[v].exp_words);
            chk($sformatf("vec%0d_first", v), obs_first, vecs[v].exp_first);
            chk($sformatf("vec%0d_last", v), obs_last, vecs[v].exp_last);
        end

        // Command strobed while a read burst is running must be ignored.
        run_read(4'd9, 4'd2, 1'b0, -1, 0, 1'b1);

        // Reset during the second write pulse: the first word stays, the rest is dropped.
        start_cmd(1'b1, 4'd5, 4'd3, acc);
        wr_data  = 8'h5A;
        wr_valid = 1'b1;
        n = 0;
        while (!wr_ready && n < 20) begin tick(); n++; end
        tick();
        wr_valid = 1'b0;
        tick();
        wr_data  = 8'hC3;
        wr_valid = 1'b1;
        n = 0;
        while (!wr_ready && n < 20) begin tick(); n++; end
        tick();
        wr_valid = 1'b0;
        chk("pre_reset_we", int'(rf_en_write), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_we", int'(rf_en_write), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_rd_valid", int'(rd_valid), 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_release_cmd_ready", int'(cmd_ready), 1);
        mem_ref[5] = 8'h5A;
        run_read(4'd5, 4'd1, 1'b0, -1, 0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 1) == 1)
                run_write(ADDR_W'($urandom), ADDR_W'($urandom), 8'h00, 1'b1, -1, 0);
            else
                run_read(ADDR_W'($urandom), ADDR_W'($urandom), 1'b1, -1, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
